// File: rtl/mips_defs.sv
// Shared MIPS fetch-side constants, the F/D pipeline record and the fetch address check.
package mips_defs;

    localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LAST  = 32'h0000_6FFC;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        adel;
    } fd_t;

    localparam fd_t FD_RESET = '{
        instr: NOP_INSTR,
        pc:    32'h0000_0000,
        pc8:   32'h0000_0008,
        adel:  1'b0
    };

    // Unsigned range check plus word alignment.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] last);
        return (addr[1:0] != 2'b00) || (addr < base) || (addr > last);
    endfunction

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: flush beats stall, stall holds, otherwise capture the fetch.
module fd_reg
    import mips_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        adel_i,
    output fd_t         fd_o
);

    fd_t fd_d;
    fd_t fd_q;
    logic [31:0] pc8;

    // Modulo-2^32 add; wrap is intentional and carries no fault.
    assign pc8 = pc_i + LINK_OFFSET;

    always_comb begin
        fd_d = fd_q;
        if (flush_i) begin
            fd_d.instr = NOP_INSTR;
            fd_d.pc    = pc_i;
            fd_d.pc8   = pc8;
            fd_d.adel  = 1'b0;
        end else if (!stall_i) begin
            fd_d.instr = adel_i ? NOP_INSTR : instr_i;
            fd_d.pc    = pc_i;
            fd_d.pc8   = pc8;
            fd_d.adel  = adel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fd_q <= FD_RESET;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign fd_o = fd_q;

endmodule

// File: rtl/fetch_pc_fd.sv
// Fetch stage: program counter, fetch address fault detection and the F/D register.
module fetch_pc_fd
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = DEF_PC_RESET,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_LAST  = DEF_IM_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_d,
    input  logic [31:0] NPC_F,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] INSTR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        EXC_ADEL_D,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;
    logic [31:0] cnt_d;
    logic [31:0] cnt_q;
    logic        adel_f;
    fd_t         fd;

    // NPC_F is taken as-is; bad addresses are flagged in D, never corrected.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (!stall) begin
            pc_d  = NPC_F;
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            cnt_q <= 32'h0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign adel_f = addr_fault(pc_q, IM_BASE, IM_LAST);

    fd_reg u_fd_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .stall_i (stall),
        .flush_i (flush_d),
        .pc_i    (pc_q),
        .instr_i (i_inst_rdata),
        .adel_i  (adel_f),
        .fd_o    (fd)
    );

    assign i_inst_addr = pc_q;
    assign INSTR_D     = fd.instr;
    assign PC_D        = fd.pc;
    assign PC8_D       = fd.pc8;
    assign EXC_ADEL_D  = fd.adel;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_pc_fd.sv
// Directed bench for fetch_pc_fd: free-run, stall, flush, fetch faults, wrap and async reset.
module tb_fetch_pc_fd;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush_d;
    logic [31:0] NPC_F;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] INSTR_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        EXC_ADEL_D;
    logic [31:0] fetch_cnt;

    logic        use_ovr;
    logic [31:0] ovr_pc;
    int          total;
    int          bad;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0001;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign i_inst_rdata = im_word(i_inst_addr);
    assign NPC_F = use_ovr ? ovr_pc : (i_inst_addr + 32'd4);

    fetch_pc_fd dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush_d      (flush_d),
        .NPC_F        (NPC_F),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .INSTR_D      (INSTR_D),
        .PC_D         (PC_D),
        .PC8_D        (PC8_D),
        .EXC_ADEL_D   (EXC_ADEL_D),
        .fetch_cnt    (fetch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        if (!stall) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush_d = 1'b0; use_ovr = 1'b0; ovr_pc = 32'h0;
        exp_cnt = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (i_inst_addr !== 32'h3000) begin bad++; $display("FAIL reset_addr got=%h exp=%h", i_inst_addr, 32'h3000); end
        total++; if (INSTR_D !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", INSTR_D); end
        total++; if (PC_D !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PC_D); end
        total++; if (PC8_D !== 32'h8) begin bad++; $display("FAIL reset_pc8 got=%h exp=8", PC8_D); end
        total++; if (EXC_ADEL_D !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", EXC_ADEL_D); end
        total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", fetch_cnt); end
    endtask

    task automatic test_free_run();
        tick();
        total++; if (INSTR_D !== 32'h2408_0001) begin bad++; $display("FAIL run_instr got=%h exp=%h", INSTR_D, 32'h2408_0001); end
        total++; if (PC_D !== 32'h3000) begin bad++; $display("FAIL run_pc got=%h exp=3000", PC_D); end
        total++; if (PC8_D !== 32'h3008) begin bad++; $display("FAIL run_pc8 got=%h exp=3008", PC8_D); end
        total++; if (fetch_cnt !== 32'h1) begin bad++; $display("FAIL run_cnt got=%h exp=1", fetch_cnt); end
        total++; if (i_inst_addr !== 32'h3004) begin bad++; $display("FAIL run_addr got=%h exp=3004", i_inst_addr); end
        tick();
        total++; if (INSTR_D !== 32'hC0DE_3004) begin bad++; $display("FAIL run2_instr got=%h exp=c0de3004", INSTR_D); end
        total++; if (i_inst_addr !== 32'h3008) begin bad++; $display("FAIL run2_addr got=%h exp=3008", i_inst_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (i_inst_addr !== 32'h3008) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=3008", i, i_inst_addr); end
            total++; if (PC_D !== 32'h3004 || INSTR_D !== 32'hC0DE_3004) begin bad++; $display("FAIL stall_fd[%0d] pc=%h instr=%h exp=3004/c0de3004", i, PC_D, INSTR_D); end
            total++; if (fetch_cnt !== 32'h2) begin bad++; $display("FAIL stall_cnt[%0d] got=%h exp=2", i, fetch_cnt); end
        end
        stall = 1'b0;
        tick();
        total++; if (i_inst_addr !== 32'h300C) begin bad++; $display("FAIL unstall_addr got=%h exp=300c", i_inst_addr); end
        total++; if (PC_D !== 32'h3008) begin bad++; $display("FAIL unstall_pc got=%h exp=3008", PC_D); end
        total++; if (fetch_cnt !== exp_cnt) begin bad++; $display("FAIL unstall_cnt got=%h exp=%h", fetch_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush_d = 1'b1;
        tick();
        stall = 1'b0; flush_d = 1'b0;
        total++; if (INSTR_D !== 32'h0) begin bad++; $display("FAIL sf_instr got=%h exp=0", INSTR_D); end
        total++; if (PC_D !== 32'h3010) begin bad++; $display("FAIL sf_pc got=%h exp=3010", PC_D); end
        total++; if (PC8_D !== 32'h3018) begin bad++; $display("FAIL sf_pc8 got=%h exp=3018", PC8_D); end
        total++; if (EXC_ADEL_D !== 1'b0) begin bad++; $display("FAIL sf_adel got=%b exp=0", EXC_ADEL_D); end
        total++; if (i_inst_addr !== 32'h3010) begin bad++; $display("FAIL sf_addr got=%h exp=3010", i_inst_addr); end
        total++; if (fetch_cnt !== 32'h4) begin bad++; $display("FAIL sf_cnt got=%h exp=4", fetch_cnt); end
        tick();
        total++; if (INSTR_D !== 32'hC0DE_3010 || i_inst_addr !== 32'h3014) begin bad++; $display("FAIL sf_resume instr=%h addr=%h exp=c0de3010/3014", INSTR_D, i_inst_addr); end
    endtask

    task automatic test_adel();
        logic [31:0] addrs [5];
        logic        flts  [5];
        logic [31:0] ei;
        addrs[0] = 32'h3002; flts[0] = 1'b1;
        addrs[1] = 32'h7000; flts[1] = 1'b1;
        addrs[2] = 32'h6FFC; flts[2] = 1'b0;
        addrs[3] = 32'h2FFC; flts[3] = 1'b1;
        addrs[4] = 32'h3000; flts[4] = 1'b0;
        use_ovr = 1'b1; ovr_pc = addrs[0];
        tick();
        for (int k = 0; k < 5; k++) begin
            ovr_pc = (k < 4) ? addrs[k+1] : 32'h3000;
            tick();
            ei = flts[k] ? 32'h0 : im_word(addrs[k]);
            total++; if (PC_D !== addrs[k] || EXC_ADEL_D !== flts[k] || INSTR_D !== ei) begin
                bad++; $display("FAIL adel[%0d] pc=%h adel=%b instr=%h exp=%h/%b/%h", k, PC_D, EXC_ADEL_D, INSTR_D, addrs[k], flts[k], ei);
            end
        end
        use_ovr = 1'b0;
        total++; if (fetch_cnt !== exp_cnt) begin bad++; $display("FAIL adel_cnt got=%h exp=%h", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_flush_only();
        flush_d = 1'b1;
        tick();
        flush_d = 1'b0;
        total++; if (INSTR_D !== 32'h0 || PC_D !== 32'h3000) begin bad++; $display("FAIL fl_fd instr=%h pc=%h exp=0/3000", INSTR_D, PC_D); end
        total++; if (i_inst_addr !== 32'h3004) begin bad++; $display("FAIL fl_addr got=%h exp=3004", i_inst_addr); end
        total++; if (fetch_cnt !== exp_cnt) begin bad++; $display("FAIL fl_cnt got=%h exp=%h", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        use_ovr = 1'b1; ovr_pc = 32'hFFFF_FFFC;
        tick();
        ovr_pc = 32'h2FFC;
        tick();
        total++; if (PC8_D !== 32'h4) begin bad++; $display("FAIL wrap_pc8 got=%h exp=4", PC8_D); end
        total++; if (EXC_ADEL_D !== 1'b1 || PC_D !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fd adel=%b pc=%h exp=1/fffffffc", EXC_ADEL_D, PC_D); end
        // Flush while the fetch address is illegal must not raise the fault.
        flush_d = 1'b1; ovr_pc = 32'h3000;
        tick();
        flush_d = 1'b0; use_ovr = 1'b0;
        total++; if (EXC_ADEL_D !== 1'b0 || PC_D !== 32'h2FFC || PC8_D !== 32'h3004) begin
            bad++; $display("FAIL flush_adel adel=%b pc=%h pc8=%h exp=0/2ffc/3004", EXC_ADEL_D, PC_D, PC8_D);
        end
    endtask

    task automatic test_async_reset();
        use_ovr = 1'b1; ovr_pc = 32'h4000;
        tick();
        use_ovr = 1'b0; stall = 1'b1;
        total++; if (i_inst_addr !== 32'h4000) begin bad++; $display("FAIL ar_pre_addr got=%h exp=4000", i_inst_addr); end
        #2 reset = 1'b1;
        #1;
        total++; if (i_inst_addr !== 32'h3000) begin bad++; $display("FAIL ar_addr got=%h exp=3000", i_inst_addr); end
        total++; if (INSTR_D !== 32'h0 || PC_D !== 32'h0 || PC8_D !== 32'h8 || EXC_ADEL_D !== 1'b0) begin
            bad++; $display("FAIL ar_fd instr=%h pc=%h pc8=%h adel=%b exp=0/0/8/0", INSTR_D, PC_D, PC8_D, EXC_ADEL_D);
        end
        total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL ar_cnt got=%h exp=0", fetch_cnt); end
        #2 reset = 1'b0; stall = 1'b0;
        exp_cnt = 32'h0;
        tick();
        total++; if (PC_D !== 32'h3000 || i_inst_addr !== 32'h3004 || fetch_cnt !== exp_cnt) begin
            bad++; $display("FAIL ar_resume pc=%h addr=%h cnt=%h exp=3000/3004/%h", PC_D, i_inst_addr, fetch_cnt, exp_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_stall_flush();
        test_adel();
        test_flush_only();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
